// File: rtl/perf_counter_unit_if.sv
// ---------------------------------------------------------------------------
// perf_counter_unit_if
// Bundles the control inputs, pipeline event inputs and count outputs of the
// performance counter unit.
//   master : pipeline control / register-file side; drives start, finish,
//            clear, stall, retire_valid, retire_class and observes the counts.
//   slave  : the counter unit itself.
// Parameter CW is the width of every counter.
// ---------------------------------------------------------------------------
interface perf_counter_unit_if #(
    parameter int CW = 19
);
    logic          start;
    logic          finish;
    logic          clear;
    logic          stall;
    logic          retire_valid;
    logic [1:0]    retire_class;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] aritmetric_count;
    logic [CW-1:0] memory_count;
    logic [CW-1:0] instruction_count;
    logic [CW-1:0] cycle_count;
    logic          running;
    logic          done;
    logic          saturated;

    modport master (
        output start, finish, clear, stall, retire_valid, retire_class,
        input  stall_count, aritmetric_count, memory_count, instruction_count,
               cycle_count, running, done, saturated
    );

    modport slave (
        input  start, finish, clear, stall, retire_valid, retire_class,
        output stall_count, aritmetric_count, memory_count, instruction_count,
               cycle_count, running, done, saturated
    );
endinterface

// File: rtl/perf_counter_unit.sv
// ---------------------------------------------------------------------------
// perf_counter_unit
// Pipeline event counter feeding the scalar register file. Runs from a start
// pulse until the register file raises finish, counting cycles, stalled
// cycles and retired instructions (total, arithmetic, memory) in saturating
// CW-bit counters.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : perf_counter_unit_if.slave (control, events, counts, status)
// ---------------------------------------------------------------------------
module perf_counter_unit #(
    parameter int CW = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    perf_counter_unit_if.slave   bus
);
    localparam logic [CW-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] cyc_q, stl_q, ari_q, mem_q, ins_q;
    logic [CW-1:0] cyc_n, stl_n, ari_n, mem_n, ins_n;
    logic          sat_q;
    logic          retire_ok;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != MAX)) ? v + 1'b1 : v;
    endfunction

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start)  state_next = RUN;
            RUN:     if (bus.finish) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (bus.clear) state_next = IDLE;
    end

    // A retire during a stall is the same instruction being held, so it is
    // not counted until it actually leaves the pipeline.
    assign retire_ok = bus.retire_valid && !bus.stall;

    // Candidate counter values; only RUN advances them (finish cycle included).
    always_comb begin
        cyc_n = sat_inc(cyc_q, state == RUN);
        stl_n = sat_inc(stl_q, (state == RUN) && bus.stall);
        ins_n = sat_inc(ins_q, (state == RUN) && retire_ok);
        ari_n = sat_inc(ari_q, (state == RUN) && retire_ok && (bus.retire_class == 2'd1));
        mem_n = sat_inc(mem_q, (state == RUN) && retire_ok && (bus.retire_class == 2'd2));
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state <= IDLE;
            cyc_q <= '0;
            stl_q <= '0;
            ari_q <= '0;
            mem_q <= '0;
            ins_q <= '0;
            sat_q <= 1'b0;
        end else if (bus.clear) begin
            state <= IDLE;
            cyc_q <= '0;
            stl_q <= '0;
            ari_q <= '0;
            mem_q <= '0;
            ins_q <= '0;
            sat_q <= 1'b0;
        end else begin
            state <= state_next;
            cyc_q <= cyc_n;
            stl_q <= stl_n;
            ari_q <= ari_n;
            mem_q <= mem_n;
            ins_q <= ins_n;
            // Sticky: set on the edge any counter lands on its ceiling.
            if ((cyc_n == MAX) || (stl_n == MAX) || (ari_n == MAX) ||
                (mem_n == MAX) || (ins_n == MAX))
                sat_q <= 1'b1;
        end
    end

    assign bus.cycle_count       = cyc_q;
    assign bus.stall_count       = stl_q;
    assign bus.aritmetric_count  = ari_q;
    assign bus.memory_count      = mem_q;
    assign bus.instruction_count = ins_q;
    assign bus.saturated         = sat_q;
    assign bus.running           = (state == RUN);
    assign bus.done              = (state == DONE);
endmodule

// File: tb/tb_perf_counter_unit.sv
// ---------------------------------------------------------------------------
// tb_perf_counter_unit
// Drives two instances (CW=19 and CW=4) with the same directed stimulus and
// compares every output against a counting model on each falling edge, plus
// literal expectations at the end of each scenario.
// ---------------------------------------------------------------------------
module tb_perf_counter_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_r = 0, finish_r = 0, clear_r = 0, stall_r = 0, rv_r = 0;
    logic [1:0] cls_r = 0;

    perf_counter_unit_if #(.CW(19)) bus19 ();
    perf_counter_unit_if #(.CW(4))  bus4 ();

    assign bus19.start = start_r;   assign bus4.start = start_r;
    assign bus19.finish = finish_r; assign bus4.finish = finish_r;
    assign bus19.clear = clear_r;   assign bus4.clear = clear_r;
    assign bus19.stall = stall_r;   assign bus4.stall = stall_r;
    assign bus19.retire_valid = rv_r; assign bus4.retire_valid = rv_r;
    assign bus19.retire_class = cls_r; assign bus4.retire_class = cls_r;

    perf_counter_unit #(.CW(19)) dut19 (.clk(clk), .rst(rst), .bus(bus19.slave));
    perf_counter_unit #(.CW(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 running, 2 done
    typedef struct {
        int phase;
        int cyc, stl, ari, mem, ins;
        int sat;
    } model_t;

    model_t m19, m4;

    function automatic int bump(int v, int mx, bit en);
        return (en && v < mx) ? v + 1 : v;
    endfunction

    function automatic model_t advance(model_t m, int mx);
        model_t r = m;
        bit counted;
        if (clear_r) begin
            r = '{default: 0};
            return r;
        end
        if (m.phase == 0) begin
            if (start_r) r.phase = 1;
        end else if (m.phase == 1) begin
            counted = rv_r && !stall_r;
            r.cyc = bump(m.cyc, mx, 1'b1);
            r.stl = bump(m.stl, mx, stall_r);
            r.ins = bump(m.ins, mx, counted);
            r.ari = bump(m.ari, mx, counted && cls_r == 2'd1);
            r.mem = bump(m.mem, mx, counted && cls_r == 2'd2);
            if (r.cyc == mx || r.stl == mx || r.ins == mx || r.ari == mx || r.mem == mx)
                r.sat = 1;
            if (finish_r) r.phase = 2;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m19 = '{default: 0};
            m4  = '{default: 0};
        end else begin
            m19 = advance(m19, (1 << 19) - 1);
            m4  = advance(m4, 15);
        end
    end

    task automatic compare(input string tag, input model_t m,
                           input int cyc, input int stl, input int ari, input int mem,
                           input int ins, input int run, input int dn, input int sat);
        check({tag, ".cycle_count"},       cyc, m.cyc);
        check({tag, ".stall_count"},       stl, m.stl);
        check({tag, ".aritmetric_count"},  ari, m.ari);
        check({tag, ".memory_count"},      mem, m.mem);
        check({tag, ".instruction_count"}, ins, m.ins);
        check({tag, ".running"},           run, int'(m.phase == 1));
        check({tag, ".done"},              dn,  int'(m.phase == 2));
        check({tag, ".saturated"},         sat, m.sat);
    endtask

    always @(negedge clk) begin
        compare("cw19", m19, int'(bus19.cycle_count), int'(bus19.stall_count),
                int'(bus19.aritmetric_count), int'(bus19.memory_count),
                int'(bus19.instruction_count), int'(bus19.running),
                int'(bus19.done), int'(bus19.saturated));
        compare("cw4", m4, int'(bus4.cycle_count), int'(bus4.stall_count),
                int'(bus4.aritmetric_count), int'(bus4.memory_count),
                int'(bus4.instruction_count), int'(bus4.running),
                int'(bus4.done), int'(bus4.saturated));
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs, return 2 time units after the sampling edge
    // with all inputs back at zero.
    task automatic cyc(input bit st, input bit fin, input bit clr,
                       input bit stl, input bit rv, input logic [1:0] cls);
        start_r = st; finish_r = fin; clear_r = clr;
        stall_r = stl; rv_r = rv; cls_r = cls;
        @(posedge clk); #2;
        start_r = 0; finish_r = 0; clear_r = 0; stall_r = 0; rv_r = 0; cls_r = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic restart();
        cyc(0, 0, 1, 0, 0, 2'd0);
        cyc(1, 0, 0, 0, 0, 2'd0);
    endtask

    initial begin
        // Reset
        @(posedge clk); @(posedge clk); #2;
        check("reset.cycle_count", int'(bus19.cycle_count), 0);
        check("reset.running", int'(bus19.running), 0);
        rst = 0;
        idle_cycles(2);

        // 1: basic run, 10 empty cycles plus the finish cycle
        cyc(1, 0, 0, 0, 0, 2'd0);
        check("t1.running", int'(bus19.running), 1);
        check("t1.first_cycle", int'(bus19.cycle_count), 0);
        idle_cycles(10);
        cyc(0, 1, 0, 0, 0, 2'd0);
        check("t1.cycle_count", int'(bus19.cycle_count), 11);
        check("t1.done", int'(bus19.done), 1);
        check("t1.instruction_count", int'(bus19.instruction_count), 0);
        check("t1.stall_count", int'(bus19.stall_count), 0);
        idle_cycles(3);
        check("t1.frozen", int'(bus19.cycle_count), 11);

        // 2: classified retires
        restart();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 2'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 2'd2);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, 2'd3);
        cyc(0, 0, 0, 0, 1, 2'd0);
        cyc(0, 1, 0, 0, 0, 2'd0);
        check("t2.instruction_count", int'(bus19.instruction_count), 10);
        check("t2.aritmetric_count", int'(bus19.aritmetric_count), 4);
        check("t2.memory_count", int'(bus19.memory_count), 3);
        check("t2.cycle_count", int'(bus19.cycle_count), 11);

        // 3: stall masking
        restart();
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 2'd1);
        cyc(0, 0, 0, 0, 1, 2'd2);
        cyc(0, 1, 0, 0, 1, 2'd2);   // finish-cycle retire still counts
        check("t3.stall_count", int'(bus19.stall_count), 5);
        check("t3.instruction_count", int'(bus19.instruction_count), 2);
        check("t3.memory_count", int'(bus19.memory_count), 2);
        check("t3.aritmetric_count", int'(bus19.aritmetric_count), 0);

        // 4: start in DONE ignored, then clear beats finish and events
        cyc(1, 0, 0, 0, 1, 2'd1);
        check("t4.start_in_done.done", int'(bus19.done), 1);
        check("t4.start_in_done.ins", int'(bus19.instruction_count), 2);
        restart();
        cyc(0, 0, 0, 0, 1, 2'd1);
        cyc(0, 1, 1, 1, 1, 2'd1);
        check("t4.clear.running", int'(bus19.running), 0);
        check("t4.clear.done", int'(bus19.done), 0);
        check("t4.clear.cycle_count", int'(bus19.cycle_count), 0);
        check("t4.clear.instruction_count", int'(bus19.instruction_count), 0);
        check("t4.clear.stall_count", int'(bus19.stall_count), 0);

        // 5: saturation on the CW=4 instance
        restart();
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 2'd0);
        check("t5.cw4.stall_count", int'(bus4.stall_count), 15);
        check("t5.cw4.cycle_count", int'(bus4.cycle_count), 15);
        check("t5.cw4.saturated", int'(bus4.saturated), 1);
        check("t5.cw19.saturated", int'(bus19.saturated), 0);
        cyc(0, 1, 0, 0, 0, 2'd0);
        check("t5.cw19.cycle_count", int'(bus19.cycle_count), 21);
        check("t5.cw19.stall_count", int'(bus19.stall_count), 20);
        idle_cycles(2);
        check("t5.cw4.sat_sticky", int'(bus4.saturated), 1);
        cyc(0, 0, 1, 0, 0, 2'd0);
        check("t5.cw4.sat_cleared", int'(bus4.saturated), 0);
        check("t5.cw4.stall_cleared", int'(bus4.stall_count), 0);

        // 6: asynchronous reset between edges while running
        cyc(1, 0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, (i == 0), 1, 2'd1);
        check("t6.pre.instruction_count", int'(bus19.instruction_count), 2);
        rst = 1;
        #1;
        check("t6.rst.running", int'(bus19.running), 0);
        check("t6.rst.cycle_count", int'(bus19.cycle_count), 0);
        check("t6.rst.instruction_count", int'(bus19.instruction_count), 0);
        check("t6.rst.aritmetric_count", int'(bus19.aritmetric_count), 0);
        check("t6.rst.stall_count", int'(bus19.stall_count), 0);
        @(posedge clk); #2;
        rst = 0;
        idle_cycles(3);
        check("t6.waits_idle", int'(bus19.running), 0);
        cyc(1, 0, 0, 0, 0, 2'd0);
        cyc(0, 1, 0, 0, 1, 2'd3);
        check("t6.rerun.instruction_count", int'(bus19.instruction_count), 1);
        check("t6.rerun.done", int'(bus19.done), 1);
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
